// File: rtl/uart_bus_sequencer.sv
// uart_bus_sequencer: round-robin bus master that turns register read/write
// commands from two requesters into timed chip-select/strobe cycles on the
// UART's 8-bit CPU port, returning one response per accepted command.
module uart_bus_sequencer #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] AddrBus,
    output logic              n_ChipSelect,
    output logic              n_rd,
    output logic              n_we,
    output logic [DATA_W-1:0] DataBusI,
    input  logic [DATA_W-1:0] DataBusO
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              ptr;
    logic              cur_wr;
    logic              cur_id;
    logic [DATA_W-1:0] cap;

    logic              offer0;
    logic              offer1;
    logic              take0;
    logic              take1;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Next-cycle grant offer (ptr breaks ties) and selection of the accepted command.
    always_comb begin
        offer0    = req0_valid && (!req1_valid || !ptr);
        offer1    = req1_valid && (!req0_valid || ptr);
        take0     = req0_valid && req0_ready;
        take1     = req1_valid && req1_ready;
        sel_wr    = take1 ? req1_wr    : req0_wr;
        sel_addr  = take1 ? req1_addr  : req0_addr;
        sel_wdata = take1 ? req1_wdata : req0_wdata;
    end

    // Bus-cycle FSM; every output is a register, ready is offered one cycle ahead.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ptr          <= 1'b0;
            cur_wr       <= 1'b0;
            cur_id       <= 1'b0;
            req0_ready   <= 1'b0;
            req1_ready   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_rdata    <= '0;
            AddrBus      <= '0;
            n_ChipSelect <= 1'b1;
            n_rd         <= 1'b1;
            n_we         <= 1'b1;
            DataBusI     <= '0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            rsp_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (take0 || take1) begin
                        state        <= SETUP;
                        cnt          <= CNT_W'(SETUP_CYC - 1);
                        ptr          <= take0;
                        cur_id       <= take1;
                        cur_wr       <= sel_wr;
                        n_ChipSelect <= 1'b0;
                        AddrBus      <= sel_addr;
                        DataBusI     <= sel_wr ? sel_wdata : '0;
                    end else begin
                        req0_ready <= offer0;
                        req1_ready <= offer1;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= STROBE;
                        cnt   <= CNT_W'(STROBE_CYC - 1);
                        n_rd  <= cur_wr;
                        n_we  <= !cur_wr;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state <= HOLD;
                        cnt   <= CNT_W'(HOLD_CYC - 1);
                        n_rd  <= 1'b1;
                        n_we  <= 1'b1;
                        cap   <= DataBusO;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state        <= IDLE;
                        n_ChipSelect <= 1'b1;
                        AddrBus      <= '0;
                        DataBusI     <= '0;
                        rsp_valid    <= 1'b1;
                        rsp_id       <= cur_id;
                        rsp_rdata    <= cur_wr ? '0 : cap;
                        req0_ready   <= offer0;
                        req1_ready   <= offer1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Bench for uart_bus_sequencer: a register-file model of the UART answers the
// bus, and a transaction-level reference model predicts every bus cycle,
// response and arbitration decision from the command acceptance times.
module tb_uart_bus_sequencer;

    localparam int S = 1, ST = 2, H = 1, T = S + ST + H;
    localparam logic [7:0] INIT [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h3C, 8'h77, 8'h88,
                                         8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hF0, 8'h0F};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // requester inputs, main DUT
    logic       rv [2];
    logic       rw [2];
    logic [3:0] ra [2];
    logic [7:0] rd [2];
    logic       r0rdy, r1rdy, rspv, rspid, ncs, nrd, nwe;
    logic [7:0] rsprd, dbi, dbo;
    logic [3:0] abus;

    // second DUT with stretched timing
    logic       bv, bw;
    logic [3:0] ba;
    logic [7:0] bd;
    logic       b_rdy0, b_rdy1, b_rspv, b_rspid, b_ncs, b_nrd, b_nwe;
    logic [7:0] b_rsprd, b_dbi;
    logic [3:0] b_abus;

    logic [7:0] bmem [16] = INIT;
    logic [7:0] refmem [16] = INIT;

    assign dbo = bmem[abus];

    // UART register file: a write strobe with chip select stores the data bus
    always @(posedge clk) begin
        if (!ncs && !nwe) bmem[abus] <= dbi;
    end

    uart_bus_sequencer dut (
        .clk(clk), .rst(rst),
        .req0_valid(rv[0]), .req0_ready(r0rdy), .req0_wr(rw[0]), .req0_addr(ra[0]), .req0_wdata(rd[0]),
        .req1_valid(rv[1]), .req1_ready(r1rdy), .req1_wr(rw[1]), .req1_addr(ra[1]), .req1_wdata(rd[1]),
        .rsp_valid(rspv), .rsp_id(rspid), .rsp_rdata(rsprd),
        .AddrBus(abus), .n_ChipSelect(ncs), .n_rd(nrd), .n_we(nwe), .DataBusI(dbi), .DataBusO(dbo)
    );

    uart_bus_sequencer #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut2 (
        .clk(clk), .rst(rst),
        .req0_valid(bv), .req0_ready(b_rdy0), .req0_wr(bw), .req0_addr(ba), .req0_wdata(bd),
        .req1_valid(1'b0), .req1_ready(b_rdy1), .req1_wr(1'b0), .req1_addr(4'h0), .req1_wdata(8'h00),
        .rsp_valid(b_rspv), .rsp_id(b_rspid), .rsp_rdata(b_rsprd),
        .AddrBus(b_abus), .n_ChipSelect(b_ncs), .n_rd(b_nrd), .n_we(b_nwe), .DataBusI(b_dbi), .DataBusO(8'h00)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // reference model state
    int         cyc = 0, acc = 0, accepted = 0, responded = 0, dropped = 0;
    logic       busy = 1'b0, ptr = 1'b0, rst_prev = 1'b0, prev_v0 = 1'b0, prev_v1 = 1'b0;
    logic       m_wr = 1'b0, m_id = 1'b0;
    logic [3:0] m_addr = 4'h0;
    logic [7:0] m_wdata = 8'h00, m_rdata = 8'h00;
    // samples taken at the falling edge for the stimulus code
    logic       hs [2];
    logic       s_rsp, s_id, s_weL, s_cs, s_we, s_rd;
    logic [7:0] s_rdata;
    logic       b_hs, b_rsp, b_weL, b_csL;

    task automatic mon();
        int k;
        logic e_cs, e_rd, e_we, e_rsp;
        logic [3:0] e_a;
        logic [7:0] e_d;
        cyc++;
        hs[0] = 1'b0; hs[1] = 1'b0;
        s_rsp = rspv; s_id = rspid; s_rdata = rsprd; s_weL = !nwe;
        s_cs = ncs; s_we = nwe; s_rd = nrd;
        b_hs = bv && b_rdy0; b_rsp = b_rspv; b_weL = !b_nwe; b_csL = !b_ncs;
        if (rst) begin
            if (busy) dropped++;
            busy = 1'b0; ptr = 1'b0; rst_prev = 1'b1;
            prev_v0 = rv[0]; prev_v1 = rv[1];
            return;
        end
        if (rst_prev)
            chk("reset_state", 32'({ncs, nrd, nwe, abus, dbi, r0rdy, r1rdy, rspv, rspid, rsprd}),
                32'({3'b111, 4'h0, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00}));
        rst_prev = 1'b0;
        k = cyc - acc;
        e_cs = 1'b1; e_rd = 1'b1; e_we = 1'b1; e_a = 4'h0; e_d = 8'h00; e_rsp = 1'b0;
        if (busy && k >= 1 && k <= T) begin
            e_cs = 1'b0; e_a = m_addr; e_d = m_wr ? m_wdata : 8'h00;
            if (k > S && k <= S + ST) begin
                if (m_wr) e_we = 1'b0;
                else e_rd = 1'b0;
            end
        end
        if (busy && k == T + 1) e_rsp = 1'b1;
        chk("bus", 32'({ncs, nrd, nwe, abus, dbi, rspv}), 32'({e_cs, e_rd, e_we, e_a, e_d, e_rsp}));
        chk("strobe_overlap", 32'(!(!nrd && !nwe)), 32'(1));
        chk("strobe_without_cs", 32'((nrd && nwe) || !ncs), 32'(1));
        if (e_rsp) begin
            chk("rsp_id", 32'(rspid), 32'(m_id));
            chk("rsp_rdata", 32'(rsprd), 32'(m_wr ? 8'h00 : m_rdata));
            busy = 1'b0;
            responded++;
        end
        if (busy) chk("ready_while_busy", 32'({r0rdy, r1rdy}), 32'(0));
        hs[0] = rv[0] && r0rdy;
        hs[1] = rv[1] && r1rdy;
        if (hs[0] || hs[1]) begin
            chk("single_grant", 32'(hs[0] && hs[1]), 32'(0));
            if (prev_v0 && prev_v1) chk("arbitration", 32'(hs[1]), 32'(ptr));
            ptr = !hs[1];
            busy = 1'b1; acc = cyc; accepted++;
            m_id = hs[1]; m_wr = rw[m_id]; m_addr = ra[m_id]; m_wdata = rd[m_id];
            if (m_wr) refmem[m_addr] = m_wdata;
            else m_rdata = refmem[m_addr];
        end
        prev_v0 = rv[0]; prev_v1 = rv[1];
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int id);
        logic got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (hs[id]) got = 1'b1;
        end
        chk("handshake_wait", 32'(got), 32'(1));
    endtask

    task automatic wait_idle();
        logic got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (!busy) got = 1'b1;
        end
        chk("idle_wait", 32'(got), 32'(1));
    endtask

    task automatic run_cmd(input int id, input logic wr, input logic [3:0] a, input logic [7:0] d,
                           output int lat, output logic rid, output logic [7:0] rdat);
        int t;
        logic got = 1'b0;
        rv[id] = 1'b1; rw[id] = wr; ra[id] = a; rd[id] = d;
        wait_hs(id);
        t = cyc;
        rv[id] = 1'b0;
        lat = -1; rid = 1'b0; rdat = 8'h00;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (s_rsp) begin
                got = 1'b1; lat = cyc - t; rid = s_id; rdat = s_rdata;
            end
        end
        chk("rsp_wait", 32'(got), 32'(1));
    endtask

    initial begin
        int lat, n, nr, we_n, cs_n, t2;
        int gq [4];
        int gap [2];
        logic rid, got;
        logic [7:0] rdat;
        rv[0] = 0; rv[1] = 0; rw[0] = 0; rw[1] = 0; ra[0] = 0; ra[1] = 0; rd[0] = 0; rd[1] = 0;
        bv = 0; bw = 0; ba = 0; bd = 0;
        gq[0] = -1; gq[1] = -1; gq[2] = -1; gq[3] = -1;

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // single write from requester 0
        run_cmd(0, 1'b1, 4'h3, 8'hA5, lat, rid, rdat);
        chk("wr_latency", 32'(lat), 32'(5));
        chk("wr_rsp", 32'({rid, rdat}), 32'({1'b0, 8'h00}));

        // single read from requester 1
        run_cmd(1, 1'b0, 4'h5, 8'h00, lat, rid, rdat);
        chk("rd_latency", 32'(lat), 32'(5));
        chk("rd_rsp", 32'({rid, rdat}), 32'({1'b1, 8'h3C}));

        // contention from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rv[0] = 1; rw[0] = 0; ra[0] = 4'h1;
        rv[1] = 1; rw[1] = 1; ra[1] = 4'h2; rd[1] = 8'h96;
        n = 0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            tick();
            if (hs[0] || hs[1]) begin
                gq[n] = hs[1] ? 1 : 0;
                chk("back_to_back", 32'(s_rsp), 32'(n > 0));
                n++;
                ra[gq[n-1]] = 4'($urandom_range(0, 15));
                rd[gq[n-1]] = 8'($urandom_range(0, 255));
            end
        end
        rv[0] = 0; rv[1] = 0;
        chk("grant_count", 32'(n), 32'(4));
        for (int i = 0; i < 4; i++) chk("grant_order", 32'(gq[i]), 32'(i % 2));
        wait_idle();

        // reset during the strobe of a write
        rv[0] = 1; rw[0] = 1; ra[0] = 4'h7; rd[0] = 8'h5A;
        wait_hs(0);
        rv[0] = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (s_weL) got = 1'b1;
        end
        chk("strobe_seen", 32'(got), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_strobes", 32'({s_cs, s_we, s_rd}), 32'(3'b111));
        nr = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_rsp) nr++;
        end
        chk("no_rsp_after_rst", 32'(nr), 32'(0));
        rv[0] = 1; rw[0] = 0; ra[0] = 4'h2;
        rv[1] = 1; rw[1] = 0; ra[1] = 4'h4;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (hs[0] || hs[1]) got = 1'b1;
        end
        chk("post_rst_wait", 32'(got), 32'(1));
        chk("post_rst_grant", 32'(hs[1]), 32'(0));
        rv[0] = 0; rv[1] = 0;
        wait_idle();

        // stretched timing instance: SETUP=2, STROBE=3, HOLD=2
        bv = 1; bw = 1; ba = 4'h9; bd = 8'hC3;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (b_hs) got = 1'b1;
        end
        chk("b_hs_wait", 32'(got), 32'(1));
        t2 = cyc;
        bv = 0;
        we_n = 0; cs_n = 0; lat = -1; got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (b_weL) we_n++;
            if (b_csL) cs_n++;
            if (b_rsp) begin got = 1'b1; lat = cyc - t2; end
        end
        chk("b_latency", 32'(lat), 32'(8));
        chk("b_we_low", 32'(we_n), 32'(3));
        chk("b_cs_low", 32'(cs_n), 32'(7));

        // random traffic with occasional withdrawn requests
        gap[0] = 0; gap[1] = 2;
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (rv[i] && hs[i]) begin
                    rv[i] = 0; gap[i] = $urandom_range(0, 3);
                end else if (rv[i] && $urandom_range(0, 7) == 0) begin
                    rv[i] = 0; gap[i] = $urandom_range(0, 3);
                end else if (!rv[i]) begin
                    if (gap[i] == 0) begin
                        rv[i] = 1;
                        rw[i] = 1'($urandom_range(0, 1));
                        ra[i] = 4'($urandom_range(0, 15));
                        rd[i] = 8'($urandom_range(0, 255));
                    end else begin
                        gap[i]--;
                    end
                end
            end
        end
        rv[0] = 0; rv[1] = 0;
        wait_idle();
        tick();
        chk("rsp_count", 32'(responded), 32'(accepted - dropped));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
